// File: rtl/osc_clken_pkg.sv
// Shared definitions for the oscillator clock-enable generator.
//   state_e  : top-level sequencing (SETTLE while the oscillator stabilises, then RUN)
//   sel_w    : width of the channel-select field for a given channel count (min 1)
//   settle_w : width of a counter that must hold values 0..cycles
package osc_clken_pkg;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_e;

  function automatic int sel_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int settle_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/osc_clken_ch.sv
// One clock-enable channel: a divisor counter with an active divisor, a
// shadow divisor waiting to be applied, and a registered one-cycle strobe.
//   clk      : oscillator clock
//   reset    : synchronous, active-high
//   run      : top level is in RUN
//   ch_en    : channel enable (level)
//   restart  : phase-realign pulse, already qualified with run
//   wr       : accepted divisor write for this channel
//   wdata    : divisor value for the write (never zero when wr is set)
//   clken    : single-cycle enable strobe, period = active divisor
module osc_clken_ch
  import osc_clken_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             ch_en,
  input  logic             restart,
  input  logic             wr,
  input  logic [DIV_W-1:0] wdata,
  output logic             clken
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] shadow;
  logic             pending;
  logic             counting;
  logic             wrap;
  logic             apply;

  // A pending divisor only takes effect at a period boundary (wrap), on a
  // restart, or while the channel is idle, so no period is ever cut short or
  // stretched. The check uses the pending flag from before this cycle's write,
  // so a write landing on a wrap waits for the following wrap.
  always_comb begin
    counting = run && ch_en;
    wrap     = counting && (cnt == div_act - DIV_W'(1));
    apply    = pending && (restart || wrap || !counting);
  end

  // NOTE: reset is sampled on the clock edge, and every register here is
  // plain state (no memory arrays), so all of it is given a reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div_act <= DIV_W'(DEFAULT_DIV);
      shadow  <= DIV_W'(DEFAULT_DIV);
      pending <= 1'b0;
      clken   <= 1'b0;
    end else begin
      // Restart overrides both the wrap and the strobe it would produce.
      if (restart) begin
        cnt   <= '0;
        clken <= 1'b0;
      end else if (counting) begin
        cnt   <= wrap ? '0 : cnt + DIV_W'(1);
        clken <= wrap;
      end else begin
        cnt   <= '0;
        clken <= 1'b0;
      end

      if (apply) begin
        div_act <= shadow;
      end

      // A new write always re-arms pending, so the last write wins.
      if (wr) begin
        shadow  <= wdata;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/osc_clken_gen.sv
// Multi-channel clock-enable generator on the fabric oscillator clock.
// After reset it waits SETTLE_CYCLES for the oscillator to settle, then
// produces NUM_CH independent single-cycle enable strobes with runtime
// programmable divisors.
//   CLK          : oscillator clock (sole clock)
//   RESET        : synchronous, active-high
//   DIV_WE       : divisor write strobe
//   DIV_SEL      : channel index for the write
//   DIV_WDATA    : new divisor (zero is rejected)
//   CH_EN        : per-channel enable, level-sensitive
//   SYNC_RESTART : one-cycle pulse; realigns all channels (RUN only)
//   CLKEN_OUT    : registered single-cycle enable strobes
//   READY        : high in RUN
//   DIV_ERR      : one-cycle pulse after a rejected write
module osc_clken_gen
  import osc_clken_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int DIV_W         = 16,
  parameter  int DEFAULT_DIV   = 50,
  parameter  int SETTLE_CYCLES = 1024,
  localparam int SEL_W         = sel_w(NUM_CH),
  localparam int SETTLE_W      = settle_w(SETTLE_CYCLES)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DIV_WE,
  input  logic [SEL_W-1:0]  DIV_SEL,
  input  logic [DIV_W-1:0]  DIV_WDATA,
  input  logic [NUM_CH-1:0] CH_EN,
  input  logic              SYNC_RESTART,
  output logic [NUM_CH-1:0] CLKEN_OUT,
  output logic              READY,
  output logic              DIV_ERR
);

  state_e              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                run;
  logic                restart;
  logic                sel_ok;
  logic                wr_ok;
  logic [NUM_CH-1:0]   wr_ch;

  // NOTE: state registers use non-blocking assignments so every flop in the
  // block samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      READY      <= 1'b0;
    end else begin
      case (state)
        SETTLE: begin
          settle_cnt <= settle_cnt + SETTLE_W'(1);
          if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state <= RUN;
            READY <= 1'b1;
          end
        end
        RUN: begin
          READY <= 1'b1;
        end
        default: begin
          state <= SETTLE;
          READY <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every signal driven here gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    run     = (state == RUN);
    restart = SYNC_RESTART && run;
    sel_ok  = int'(DIV_SEL) < NUM_CH;
    wr_ok   = DIV_WE && sel_ok && (|DIV_WDATA);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DIV_ERR <= 1'b0;
    end else begin
      DIV_ERR <= DIV_WE && !(sel_ok && (|DIV_WDATA));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch[i] = wr_ok && (DIV_SEL == SEL_W'(i));

    osc_clken_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (CLK),
      .reset   (RESET),
      .run     (run),
      .ch_en   (CH_EN[i]),
      .restart (restart),
      .wr      (wr_ch[i]),
      .wdata   (DIV_WDATA),
      .clken   (CLKEN_OUT[i])
    );
  end

endmodule
